// File: rtl/raystore_writer_pkg.sv
// Shared types and constants for the raystore writer slice.
//   ray_vec_t  : ray origin/direction as written into the raystore
//   rayid_t    : raystore slot index / rayID
//   pool_state_e : free-pool fill state (INIT fill, then RUN)
package raystore_writer_pkg;

    localparam int NUM_RAYS   = 512;
    localparam int RAYID_W    = $clog2(NUM_RAYS);
    localparam int POOL_CNT_W = RAYID_W + 1;          // holds 0..NUM_RAYS
    localparam int MAX_BURST  = 4;
    localparam int BURST_W    = $clog2(MAX_BURST + 1);
    localparam int TOK_K      = 2;
    localparam int TOK_DEPTH  = 1 << TOK_K;

    typedef logic [RAYID_W-1:0] rayid_t;

    typedef struct packed {
        logic [31:0] org_x;
        logic [31:0] org_y;
        logic [31:0] org_z;
        logic [31:0] dir_x;
        logic [31:0] dir_y;
        logic [31:0] dir_z;
    } ray_vec_t;

    typedef enum logic {
        POOL_INIT,
        POOL_RUN
    } pool_state_e;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO, 2**K entries of WIDTH bits, show-ahead read.
//   clk, rst         : clock, synchronous active-high reset
//   push, push_data  : write request and data (ignored while full)
//   pop              : consume head (ignored while empty)
//   pop_data         : current head, valid while ~empty
//   empty, count     : occupancy status (count is 0..2**K)
module fifo #(
    parameter int WIDTH = 8,
    parameter int K     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [K:0]       count
);

    logic [WIDTH-1:0] mem [2**K];
    logic [K-1:0]     rd_ptr;
    logic [K-1:0]     wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // count never exceeds 2**K, so its top bit alone flags full.
    assign full     = count[K];
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (K+1)'(do_push) - (K+1)'(do_pop);
        end
    end

endmodule

// File: rtl/rayid_pool.sv
// Circular free-ID pool. After reset it fills itself with IDs 0..NUM_RAYS-1
// (one per cycle), then serves IDs in FIFO order of return.
//   clk, rst    : clock, synchronous active-high reset
//   pop         : consume head_id this cycle (caller guarantees cnt != 0)
//   free_valid, free_id : ID returned to the tail
//   head_id     : current head, usable combinationally in the pop cycle
//   cnt         : number of free IDs (0..NUM_RAYS)
//   init_done   : fill finished, pool serving
//   err         : sticky; free while full (no same-cycle pop) or during fill
module rayid_pool
    import raystore_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pop,
    input  logic                  free_valid,
    input  rayid_t                free_id,
    output rayid_t                head_id,
    output logic [POOL_CNT_W-1:0] cnt,
    output logic                  init_done,
    output logic                  err
);

    pool_state_e state;
    rayid_t      init_cnt;
    rayid_t      mem [NUM_RAYS];
    rayid_t      rd_ptr;
    rayid_t      wr_ptr;
    rayid_t      next_rd_ptr;
    rayid_t      push_id;
    logic        push;
    logic        take;
    logic        full;

    assign full = (cnt == POOL_CNT_W'(NUM_RAYS));
    assign take = pop & (state == POOL_RUN);
    // Pointers are exactly RAYID_W bits, so natural overflow wraps modulo NUM_RAYS.
    assign next_rd_ptr = take ? rd_ptr + 1'b1 : rd_ptr;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        push    = 1'b0;
        push_id = free_id;
        if (state == POOL_INIT) begin
            push    = 1'b1;
            push_id = init_cnt;
        end else if (free_valid && (!full || take)) begin
            push = 1'b1;
        end
    end

    // NOTE: the ID storage has no reset so it maps onto block RAM; the pointers and count alone define which entries are live.
    // The head register is refreshed every cycle from the slot that will be the head next cycle;
    // when that slot is being written right now (pool empty or draining to empty) the incoming ID bypasses the RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_id;
        end
        head_id <= (push && (wr_ptr == next_rd_ptr)) ? push_id : mem[next_rd_ptr];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= POOL_INIT;
            init_cnt  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= next_rd_ptr;
            cnt    <= cnt + POOL_CNT_W'(push) - POOL_CNT_W'(take);
            if (state == POOL_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (free_valid) err <= 1'b1;
                if (init_cnt == rayid_t'(NUM_RAYS - 1)) begin
                    state     <= POOL_RUN;
                    init_done <= 1'b1;
                end
            end else if (free_valid && full && !take) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/raystore_writer.sv
// Upstream feeder of the raystore: allocates a free rayID per new ray, writes
// the ray into the raystore, then hands the ID to traversal as a start token.
// Write bursts are capped at MAX_BURST cycles because writes block reads.
//   clk, rst                       : clock, synchronous active-high reset
//   prg_ray, prg_valid, prg_stall  : new rays from the primary ray generator
//   free_id, free_valid            : retired IDs returning to the pool
//   raystore_we/_write_addr/_write_data : registered raystore write port
//   start_id, start_valid, start_stall  : start tokens to traversal
//   init_done                      : pool filled, block accepting
//   pool_err                       : sticky illegal-free flag
module raystore_writer
    import raystore_writer_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  ray_vec_t prg_ray,
    input  logic     prg_valid,
    output logic     prg_stall,
    input  rayid_t   free_id,
    input  logic     free_valid,
    output logic     raystore_we,
    output rayid_t   raystore_write_addr,
    output ray_vec_t raystore_write_data,
    output rayid_t   start_id,
    output logic     start_valid,
    input  logic     start_stall,
    output logic     init_done,
    output logic     pool_err
);

    rayid_t                head_id;
    logic [POOL_CNT_W-1:0] pool_cnt;
    logic [BURST_W-1:0]    burst_cnt;
    logic [TOK_K:0]        tok_cnt;
    logic                  tok_empty;
    logic                  tok_room;
    logic                  throttle;
    logic                  accept;

    // raystore_we doubles as the write-pending flag: that write's token enters
    // the FIFO at the end of this cycle, so it already claims a slot.
    assign tok_room = (int'(tok_cnt) + int'(raystore_we)) < TOK_DEPTH;
    assign throttle = (burst_cnt == BURST_W'(MAX_BURST));
    assign accept   = init_done & prg_valid & (pool_cnt != '0) & tok_room & ~throttle;
    // Stall is held high for the whole fill so nothing upstream sees a window before the pool exists.
    assign prg_stall   = ~init_done | (prg_valid & ~accept);
    assign start_valid = ~tok_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            raystore_we         <= 1'b0;
            raystore_write_addr <= '0;
            raystore_write_data <= '0;
            burst_cnt           <= '0;
        end else begin
            raystore_we <= accept;
            burst_cnt   <= accept ? burst_cnt + 1'b1 : '0;
            if (accept) begin
                raystore_write_addr <= head_id;
                raystore_write_data <= prg_ray;
            end
        end
    end

    rayid_pool u_pool (
        .clk        (clk),
        .rst        (rst),
        .pop        (accept),
        .free_valid (free_valid),
        .free_id    (free_id),
        .head_id    (head_id),
        .cnt        (pool_cnt),
        .init_done  (init_done),
        .err        (pool_err)
    );

    // The token is pushed in the write cycle itself, so traversal sees the ID
    // only after the raystore write has committed.
    fifo #(
        .WIDTH (RAYID_W),
        .K     (TOK_K)
    ) u_tok_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (raystore_we),
        .push_data (raystore_write_addr),
        .pop       (start_valid & ~start_stall),
        .pop_data  (start_id),
        .empty     (tok_empty),
        .count     (tok_cnt)
    );

endmodule

// File: tb/tb_raystore_writer.sv
// Self-checking bench for raystore_writer: queue-level reference model checked
// every cycle, plus directed scenarios with hand-derived literal expectations.
module tb_raystore_writer;
    import raystore_writer_pkg::*;

    logic     clk;
    logic     rst;
    ray_vec_t prg_ray;
    logic     prg_valid;
    logic     prg_stall;
    rayid_t   free_id;
    logic     free_valid;
    logic     raystore_we;
    rayid_t   raystore_write_addr;
    ray_vec_t raystore_write_data;
    rayid_t   start_id;
    logic     start_valid;
    logic     start_stall;
    logic     init_done;
    logic     pool_err;

    raystore_writer dut (
        .clk                 (clk),
        .rst                 (rst),
        .prg_ray             (prg_ray),
        .prg_valid           (prg_valid),
        .prg_stall           (prg_stall),
        .free_id             (free_id),
        .free_valid          (free_valid),
        .raystore_we         (raystore_we),
        .raystore_write_addr (raystore_write_addr),
        .raystore_write_data (raystore_write_data),
        .start_id            (start_id),
        .start_valid         (start_valid),
        .start_stall         (start_stall),
        .init_done           (init_done),
        .pool_err            (pool_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit       m_live = 1'b0;
    bit       m_running;
    int       m_init_cnt;
    rayid_t   pool_q[$];
    rayid_t   tok_q[$];
    rayid_t   outst[$];       // IDs handed to traversal, eligible to be freed
    bit       m_wr_v;
    rayid_t   m_wr_id;
    ray_vec_t m_wr_data;
    int       m_run;          // consecutive accepted cycles just before now
    bit       m_err;

    function automatic bit model_accept();
        return m_running && prg_valid && (pool_q.size() != 0) &&
               ((tok_q.size() + int'(m_wr_v)) < TOK_DEPTH) && (m_run < MAX_BURST);
    endfunction

    always @(posedge clk) begin
        bit     acc;
        bit     tok_pop;
        rayid_t id;
        if (rst) begin
            m_live = 1'b1;
            m_running = 1'b0;
            m_init_cnt = 0;
            pool_q.delete();
            tok_q.delete();
            outst.delete();
            m_wr_v = 1'b0;
            m_wr_id = '0;
            m_wr_data = '0;
            m_run = 0;
            m_err = 1'b0;
        end else if (m_live) begin
            acc = model_accept();
            tok_pop = (tok_q.size() != 0) && !start_stall;
            id = '0;
            if (!m_running) begin
                pool_q.push_back(rayid_t'(m_init_cnt));
                m_init_cnt++;
                if (free_valid) m_err = 1'b1;
                if (m_init_cnt == NUM_RAYS) m_running = 1'b1;
            end else begin
                if (acc) id = pool_q.pop_front();
                if (free_valid) begin
                    if (pool_q.size() == NUM_RAYS) m_err = 1'b1;
                    else pool_q.push_back(free_id);
                end
            end
            if (tok_pop) outst.push_back(tok_q.pop_front());
            if (m_wr_v) tok_q.push_back(m_wr_id);
            m_wr_v = acc;
            if (acc) begin
                m_wr_id = id;
                m_wr_data = prg_ray;
            end
            m_run = acc ? m_run + 1 : 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            check("prg_stall", 256'(prg_stall), 256'(!m_running || (prg_valid && !model_accept())));
            check("raystore_we", 256'(raystore_we), 256'(m_wr_v));
            if (m_wr_v) begin
                check("raystore_write_addr", 256'(raystore_write_addr), 256'(m_wr_id));
                check("raystore_write_data", 256'(raystore_write_data), 256'(m_wr_data));
            end
            check("start_valid", 256'(start_valid), 256'(tok_q.size() != 0));
            if (tok_q.size() != 0) check("start_id", 256'(start_id), 256'(tok_q[0]));
            check("init_done", 256'(init_done), 256'(m_running));
            check("pool_err", 256'(pool_err), 256'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic ray_vec_t rand_ray();
        ray_vec_t r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        prg_ray = rand_ray();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        prg_valid = 1'b0;
        free_valid = 1'b0;
        start_stall = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] we_pat;
        logic [11:0] sv_pat;
        rayid_t      addrs[$];
        rayid_t      ids[$];
        int          nw;

        rst = 1'b1;
        prg_ray = '0;
        prg_valid = 1'b0;
        free_id = '0;
        free_valid = 1'b0;
        start_stall = 1'b0;

        // T1 + T2: stall through INIT, then 10 back-to-back rays
        do_reset(3);
        prg_valid = 1'b1;
        we_pat = '0;
        sv_pat = '0;
        for (int c = 0; c <= 526; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("t1_rst_we", 256'(raystore_we), 256'(0));
                check("t1_rst_addr", 256'(raystore_write_addr), 256'(0));
                check("t1_rst_data", 256'(raystore_write_data), 256'(0));
                check("t1_rst_start_valid", 256'(start_valid), 256'(0));
                check("t1_rst_pool_err", 256'(pool_err), 256'(0));
            end
            if (c < 512) begin
                check("t1_init_stall", 256'(prg_stall), 256'(1));
                check("t1_init_done_low", 256'(init_done), 256'(0));
            end
            if (c == 512) check("t1_init_done_rise", 256'(init_done), 256'(1));
            if (c >= 513 && c <= 524) begin
                we_pat = {we_pat[10:0], raystore_we};
                if (raystore_we) addrs.push_back(raystore_write_addr);
            end
            if (c >= 514 && c <= 525) begin
                sv_pat = {sv_pat[10:0], start_valid};
                if (start_valid) ids.push_back(start_id);
            end
            tick();
            if (c == 523) prg_valid = 1'b0;
        end
        check("t2_we_pattern", 256'(we_pat), 256'(12'b1111_0_1111_0_11));
        check("t2_start_valid_pattern", 256'(sv_pat), 256'(12'b1111_0_1111_0_11));
        check("t2_write_count", 256'(addrs.size()), 256'(10));
        check("t2_token_count", 256'(ids.size()), 256'(10));
        for (int i = 0; i < addrs.size() && i < 10; i++)
            check($sformatf("t2_addr%0d", i), 256'(addrs[i]), 256'(i));
        for (int i = 0; i < ids.size() && i < 10; i++)
            check($sformatf("t2_start_id%0d", i), 256'(ids[i]), 256'(i));

        // T3: traversal stalled -> exactly TOK_DEPTH writes, then drain and resume
        repeat (4) tick();
        start_stall = 1'b1;
        prg_valid = 1'b1;
        nw = 0;
        repeat (12) begin
            @(negedge clk);
            nw += int'(raystore_we);
            tick();
        end
        check("t3_write_count", 256'(nw), 256'(TOK_DEPTH));
        @(negedge clk);
        check("t3_stall_full", 256'(prg_stall), 256'(1));
        tick();
        start_stall = 1'b0;
        ids.delete();
        repeat (12) begin
            @(negedge clk);
            if (start_valid) ids.push_back(start_id);
            tick();
        end
        check("t3_token_count", 256'(ids.size() >= 5), 256'(1));
        for (int i = 0; i < ids.size() && i < 5; i++)
            check($sformatf("t3_start_id%0d", i), 256'(ids[i]), 256'(10 + i));
        prg_valid = 1'b0;
        repeat (6) tick();

        // T4: exhaust the pool, then a single free of 37 is the next write address
        prg_valid = 1'b1;
        repeat (1200) begin
            start_stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        start_stall = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("t4_pool_empty_stall", 256'(prg_stall), 256'(1));
        tick();
        for (int i = 0; i < outst.size(); i++) begin
            if (outst[i] == rayid_t'(37)) begin
                outst.delete(i);
                break;
            end
        end
        free_valid = 1'b1;
        free_id = rayid_t'(37);
        @(negedge clk);
        check("t4_stall_before_free_lands", 256'(prg_stall), 256'(1));
        tick();
        free_valid = 1'b0;
        @(negedge clk);
        check("t4_resume_after_free", 256'(prg_stall), 256'(0));
        tick();
        @(negedge clk);
        check("t4_we_after_free", 256'(raystore_we), 256'(1));
        check("t4_addr_37", 256'(raystore_write_addr), 256'(37));
        tick();

        // Random traffic with legal frees
        repeat (3000) begin
            prg_valid = ($urandom_range(0, 9) < 7);
            start_stall = ($urandom_range(0, 9) < 3);
            if (outst.size() > 0 && $urandom_range(0, 9) < 4) begin
                int idx;
                idx = $urandom_range(0, outst.size() - 1);
                free_id = outst[idx];
                outst.delete(idx);
                free_valid = 1'b1;
            end else begin
                free_valid = 1'b0;
            end
            tick();
        end
        prg_valid = 1'b0;
        free_valid = 1'b0;
        start_stall = 1'b0;
        repeat (6) tick();

        // T5: free while full right after INIT; free during INIT
        do_reset(2);
        repeat (512) tick();
        free_valid = 1'b1;
        free_id = rayid_t'(5);
        tick();
        free_valid = 1'b0;
        @(negedge clk);
        check("t5_err_full_free", 256'(pool_err), 256'(1));
        prg_valid = 1'b1;
        repeat (700) tick();
        prg_valid = 1'b0;
        @(negedge clk);
        check("t5_err_sticky", 256'(pool_err), 256'(1));
        check("t5_dropped_free_pool_empty", 256'(prg_stall), 256'(0));
        tick();
        do_reset(2);
        @(negedge clk);
        check("t5_rst_clears_err", 256'(pool_err), 256'(0));
        repeat (10) tick();
        free_valid = 1'b1;
        free_id = rayid_t'(3);
        tick();
        free_valid = 1'b0;
        @(negedge clk);
        check("t5_err_init_free", 256'(pool_err), 256'(1));

        // T6: reset during a write burst
        do_reset(2);
        repeat (512) tick();
        prg_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("t6_we_mid_burst", 256'(raystore_we), 256'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_we_after_rst", 256'(raystore_we), 256'(0));
        check("t6_start_valid_after_rst", 256'(start_valid), 256'(0));
        check("t6_init_done_after_rst", 256'(init_done), 256'(0));
        check("t6_stall_after_rst", 256'(prg_stall), 256'(1));
        repeat (512) tick();
        @(negedge clk);
        check("t6_init_done_again", 256'(init_done), 256'(1));
        tick();
        @(negedge clk);
        check("t6_first_we", 256'(raystore_we), 256'(1));
        check("t6_first_addr", 256'(raystore_write_addr), 256'(0));
        tick();
        prg_valid = 1'b0;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
